// File: rtl/fa_using_mux4_pkg.sv
// Shared definitions for the mux-based full adder: select encoding for the
// {a,b} select of the per-bit 4:1 multiplexers.
package fa_using_mux4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_00 = 2'b00;
    localparam sel_t SEL_01 = 2'b01;
    localparam sel_t SEL_10 = 2'b10;
    localparam sel_t SEL_11 = 2'b11;

    function automatic sel_t make_sel(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/fa_using_mux4_cell.sv
// One full-adder bit built from two case-based 4:1 multiplexers selected by
// {a,b}, with the carry-in as the data term.
module fa_mux4_cell
    import fa_using_mux4_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    sel_t sel;

    assign sel = make_sel(a, b);

    // Default arms drive 0 so an X/Z select resolves to a known value.
    always_comb begin
        s = 1'b0;
        case (sel)
            SEL_00:  s = ci;
            SEL_01:  s = ~ci;
            SEL_10:  s = ~ci;
            SEL_11:  s = ci;
            default: s = 1'b0;
        endcase
    end

    always_comb begin
        co = 1'b0;
        case (sel)
            SEL_00:  co = 1'b0;
            SEL_01:  co = ci;
            SEL_10:  co = ci;
            SEL_11:  co = 1'b1;
            default: co = 1'b0;
        endcase
    end

endmodule

// File: rtl/fa_using_mux4.sv
// Registered ripple adder: WIDTH mux-based full-adder cells chained through
// their carries, with sum and carry-out captured on the rising clock edge.
module fa_using_mux4
    import fa_using_mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p1;
    logic             carry_p1;

    // Stage p0: combinational ripple chain
    assign carry_p0[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_mux4_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry_p0[i]),
            .s  (sum_p0[i]),
            .co (carry_p0[i+1])
        );
    end

    // Stage p1: output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1   <= '0;
            carry_p1 <= 1'b0;
        end else begin
            sum_p1   <= sum_p0;
            carry_p1 <= carry_p0[WIDTH];
        end
    end

    assign Sum   = sum_p1;
    assign Carry = carry_p1;

endmodule

// File: tb/tb_fa_using_mux4.sv
// Scoreboard bench for fa_using_mux4 at WIDTH=1 and WIDTH=8, checked against
// plain integer addition delayed by one clock.
module tb_fa_using_mux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic       s1, co1;
    logic [7:0] s8;
    logic       co8;

    int tests = 0;
    int fails = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];

    always #5 clk = ~clk;

    fa_using_mux4 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .Sum(s1), .Carry(co1)
    );

    fa_using_mux4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .Sum(s8), .Carry(co8)
    );

    // Drive one operand set for both instances and queue what each must show
    // one edge later.
    task automatic apply(input logic r,
                         input logic na1, input logic nb1, input logic nc1,
                         input logic [7:0] na8, input logic [7:0] nb8, input logic nc8);
        int e1;
        int e8;
        @(negedge clk);
        rst = r; a1 = na1; b1 = nb1; c1 = nc1;
        a8 = na8; b8 = nb8; c8 = nc8;
        e1 = int'(na1) + int'(nb1) + int'(nc1);
        e8 = int'(na8) + int'(nb8) + int'(nc8);
        q1.push_back(r ? 2'b00 : 2'(e1));
        q8.push_back(r ? 9'h000 : 9'(e8));
    endtask

    // Monitor: one result per edge from each instance.
    initial begin
        logic [1:0] x1;
        logic [8:0] x8;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                x1 = q1.pop_front();
                tests++;
                if ({co1, s1} !== x1) begin
                    fails++;
                    $display("FAIL w1_result: got C=%b S=%b, expected C=%b S=%b (A=%b B=%b Cin=%b)",
                             co1, s1, x1[1], x1[0], a1, b1, c1);
                end
            end
            if (q8.size() > 0) begin
                x8 = q8.pop_front();
                tests++;
                if ({co8, s8} !== x8) begin
                    fails++;
                    $display("FAIL w8_result: got C=%b S=%h, expected C=%b S=%h (A=%h B=%h Cin=%b)",
                             co8, s8, x8[8], x8[7:0], a8, b8, c8);
                end
            end
        end
    end

    initial begin
        logic [2:0] v;
        // Reset held for two edges with all-ones operands.
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);

        // Full truth table; WIDTH=8 sees the same bit in the LSB.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            apply(1'b0, v[2], v[1], v[0], {7'h00, v[2]}, {7'h00, v[1]}, v[0]);
        end

        // Back-to-back operand changes.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 8'h01, 1'b1);

        // Reset in the middle of a stream.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 8'hC0, 8'h40, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 8'h40, 1'b1);

        // Ripple corner cases.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h5A, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            apply(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #2;
        tests++;
        if (q1.size() != 0 || q8.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d results unchecked, expected 0/0", q1.size(), q8.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fa_using_mux4.md
Name: fa_using_mux4

Overview:
- Registered full adder. Each bit is built from two 4:1 multiplexers selected by {A,B}, with the carry-in as the data term.
- WIDTH cells are chained ripple-style. Sum and carry-out are captured in output registers on the rising clock edge.
- Serves as the mux-based adder leaf for datapath/teaching builds. Default WIDTH=1 gives a classic single-bit full adder.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64); 1 yields a single-bit full adder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  addend A.
- B  input  WIDTH  addend B.
- Cin  input  1  carry-in to bit 0.
- Sum  output  WIDTH  registered sum bits.
- Carry  output  1  registered carry-out of the MSB cell.

Behaviour:
- Reset: on a rising clk with rst=1, Sum<=0 and Carry<=0. rst has priority over data capture. No asynchronous path; outputs change only on clk edges.
- Per-bit cell i:
  - Select is sel={A[i],B[i]}; ci is the cell's carry-in (Cin for i=0, carry of cell i-1 otherwise).
  - Sum mux: 00->ci, 01->~ci, 10->~ci, 11->ci.
  - Carry mux: 00->0, 01->ci, 10->ci, 11->1.
  - Both muxes are implemented as case statements over sel with a default arm. The default drives 0 (covers X/Z select in simulation).
- Ripple: cell i's carry output feeds cell i+1's ci. The MSB cell's carry is the module Carry.
- Arithmetic: {Carry,Sum} = A + B + Cin, computed in WIDTH+1 bits with unsigned wrap. Max case A=B=all-ones, Cin=1 gives Sum=all-ones, Carry=1.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on Sum/Carry after edge N and hold until edge N+1.
  - A new operand set is accepted every cycle; no handshake, no stall.
- Reset mid-operation: the result being captured on a reset edge is discarded (outputs 0). The first post-reset result appears one edge after rst deasserts, using inputs present at that edge.
- Combinational path is purely combinational between input and output registers: no latches, no internal state beyond the WIDTH+1 output flops.

Decomposition:
- Shared package: sel encoding constants SEL_00..SEL_11 (2-bit localparams) used by the mux case arms.
- Sub-module fa_mux4_cell: one bit, inputs a, b, ci; outputs s, co. Contains the two case-based 4:1 muxes.
- Top level: generate loop instantiating WIDTH cells plus the output register process.

Test Plan:
- Reset: hold rst=1 for 2 edges with A=1,B=1,Cin=1 -> Sum=0, Carry=0. Deassert; after the next edge -> Sum=1, Carry=1.
- Exhaustive truth table (WIDTH=1): apply all 8 {A,B,Cin} combos, one per cycle, each checked one edge later:
  - 000->S0C0, 010->S1C0, 100->S1C0, 110->S0C1
  - 001->S1C0, 011->S0C1, 101->S0C1, 111->S1C1
- Back-to-back throughput: change inputs every cycle (001, 110, 011) -> outputs track with exactly 1-cycle lag, no dropped or duplicated results.
- Mid-stream reset: stream 111 then assert rst for one edge while inputs=101 -> output 0/0 for that cycle; next edge with rst=0 and inputs=101 -> S0C1.
- Ripple, WIDTH=8:
  - A=8'hFF, B=8'h00, Cin=1 -> Sum=8'h00, Carry=1 (full carry propagation).
  - A=8'hA5, B=8'h5A, Cin=0 -> Sum=8'hFF, Carry=0.
- Random, WIDTH=8: 1000 random A/B/Cin vectors -> {Carry,Sum} equals A+B+Cin delayed one cycle.
